// File: rtl/dp_stream_pkg.sv
// Shared types and sizing helpers for the dot-product serial stream.
`timescale 1ns/1ps
package dp_stream_pkg;

    localparam int unsigned DP_DATA_WIDTH = 8;
    localparam int unsigned DP_VEC_LENGTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } feeder_state_e;

    // Accumulator width that holds n full-scale unsigned products without overflow.
    function automatic int unsigned dp_res_w(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/dp_pending_buf.sv
// One-entry holding register for a vector pair; ready passes through when the
// entry is consumed in the same cycle.
`timescale 1ns/1ps
module dp_pending_buf
    import dp_stream_pkg::*;
#(
    parameter int unsigned W = 2 * DP_DATA_WIDTH * DP_VEC_LENGTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready_c,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_push;

    assign o_ready_c = !r_full || i_pop;
    assign w_push    = i_valid && o_ready_c;

    // A push in the same cycle as a pop refills the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/dot_product_feeder.sv
// Serialises an (A,B) vector pair as A[0..N-1] then B[0..N-1], one element per
// cycle, and produces the expected dot product one cycle after the frame ends.
`timescale 1ns/1ps
module dot_product_feeder
    import dp_stream_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DP_DATA_WIDTH,
    parameter  int unsigned VEC_LENGTH = DP_VEC_LENGTH,
    localparam int unsigned RES_W      = dp_res_w(DATA_WIDTH, VEC_LENGTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] vec_a,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] vec_b,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic                             frame_start,
    output logic                             frame_last,
    output logic [RES_W-1:0]                 exp_result,
    output logic                             exp_valid
);

    localparam int unsigned VEC_W  = DATA_WIDTH * VEC_LENGTH;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned IDX_W  = (VEC_LENGTH > 1) ? $clog2(VEC_LENGTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LENGTH - 1);

    feeder_state_e         r_state;
    feeder_state_e         w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [VEC_W-1:0]      r_act_a;
    logic [VEC_W-1:0]      r_act_b;
    logic [VEC_W-1:0]      w_act_a_nxt;
    logic [VEC_W-1:0]      w_act_b_nxt;
    logic [RES_W-1:0]      r_acc;
    logic [RES_W-1:0]      w_acc_nxt;
    logic [RES_W-1:0]      w_acc_sum;
    logic [DATA_WIDTH-1:0] w_a_el;
    logic [DATA_WIDTH-1:0] w_b_el;
    logic [PROD_W-1:0]     w_prod;

    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_frame_start;
    logic                  r_frame_last;
    logic [RES_W-1:0]      r_exp_result;
    logic                  r_exp_valid;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_dout_valid_nxt;
    logic                  w_frame_start_nxt;
    logic                  w_frame_last_nxt;
    logic [RES_W-1:0]      w_exp_result_nxt;
    logic                  w_exp_valid_nxt;

    logic                  w_pend_ready_c;
    logic                  w_pend_full;
    logic                  w_pend_load;
    logic                  w_idx_last;
    logic [2*VEC_W-1:0]    w_pend_data;

    dp_pending_buf #(
        .W (2 * VEC_W)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (in_valid),
        .o_ready_c (w_pend_ready_c),
        .i_data    ({vec_a, vec_b}),
        .i_pop     (w_pend_load),
        .o_full    (w_pend_full),
        .o_data    (w_pend_data)
    );

    assign in_ready = w_pend_ready_c;

    assign w_idx_last  = (r_idx == IDX_LAST);
    assign w_pend_load = w_pend_full &&
                         ((r_state == IDLE) || ((r_state == SEND_B) && w_idx_last));

    // MAC datapath on the element pair currently being sent.
    assign w_a_el    = r_act_a[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_el    = r_act_b[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod    = PROD_W'(w_a_el) * PROD_W'(w_b_el);
    assign w_acc_sum = r_acc + RES_W'(w_prod);

    assign w_act_a_nxt = w_pend_load ? w_pend_data[2*VEC_W-1:VEC_W] : r_act_a;
    assign w_act_b_nxt = w_pend_load ? w_pend_data[VEC_W-1:0]       : r_act_b;

    // Next state, index and accumulator.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_acc_nxt        = r_acc;
        w_exp_result_nxt = r_exp_result;
        w_exp_valid_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_load) begin
                    w_state_nxt = SEND_A;
                    w_idx_nxt   = '0;
                end
            end
            SEND_A: begin
                if (w_idx_last) begin
                    w_state_nxt = SEND_B;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            SEND_B: begin
                if (w_idx_last) begin
                    w_state_nxt      = w_pend_load ? SEND_A : IDLE;
                    w_idx_nxt        = '0;
                    w_acc_nxt        = '0;
                    w_exp_result_nxt = w_acc_sum;
                    w_exp_valid_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_acc_nxt = w_acc_sum;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
        if (w_pend_load) begin
            w_acc_nxt = '0;
        end
    end

    // Stream outputs are registered from the next state, so dout tracks r_state/r_idx.
    always_comb begin
        w_dout_nxt        = '0;
        w_dout_valid_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_frame_last_nxt  = 1'b0;
        case (w_state_nxt)
            SEND_A: begin
                w_dout_nxt        = w_act_a_nxt[int'(w_idx_nxt)*DATA_WIDTH +: DATA_WIDTH];
                w_dout_valid_nxt  = 1'b1;
                w_frame_start_nxt = (w_idx_nxt == '0);
            end
            SEND_B: begin
                w_dout_nxt       = w_act_b_nxt[int'(w_idx_nxt)*DATA_WIDTH +: DATA_WIDTH];
                w_dout_valid_nxt = 1'b1;
                w_frame_last_nxt = (w_idx_nxt == IDX_LAST);
            end
            default: begin
                w_dout_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_act_a       <= '0;
            r_act_b       <= '0;
            r_acc         <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
            r_exp_result  <= '0;
            r_exp_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_act_a       <= w_act_a_nxt;
            r_act_b       <= w_act_b_nxt;
            r_acc         <= w_acc_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_valid  <= w_dout_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_last  <= w_frame_last_nxt;
            r_exp_result  <= w_exp_result_nxt;
            r_exp_valid   <= w_exp_valid_nxt;
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;
    assign exp_result  = r_exp_result;
    assign exp_valid   = r_exp_valid;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed and random checks of dot_product_feeder with a stream-consuming
// dot-product engine model.
`timescale 1ns/1ps
module tb_dot_product_feeder;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 3;
    localparam int unsigned VW = DW * N;
    localparam int unsigned RW = 18;
    localparam int unsigned NP = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] vec_a;
    logic [VW-1:0] vec_b;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          frame_start;
    logic          frame_last;
    logic [RW-1:0] exp_result;
    logic          exp_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [VW-1:0] t_a   [NP];
    logic [VW-1:0] t_b   [NP];
    int unsigned   t_exp [NP];
    int            t_wait[NP];

    int          eng_pos;
    int          eng_frames = 0;
    logic        eng_in;
    logic        eng_prev_last;
    int unsigned eng_dot;
    logic [DW-1:0] eng_el[2*N];

    always #5 clk = ~clk;

    dot_product_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .vec_a       (vec_a),
        .vec_b       (vec_b),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .exp_result  (exp_result),
        .exp_valid   (exp_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] v3(input int e0, input int e1, input int e2);
        return {8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Present a pair until taken; returns at posedge+1 after the accepting edge.
    task automatic drive_pair(input logic [VW-1:0] a, input logic [VW-1:0] b, input int exp_wait);
        int waited = 0;
        in_valid = 1'b1;
        vec_a    = a;
        vec_b    = b;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (exp_wait >= 0) chk("accept_wait", waited, exp_wait);
        else if (waited >= 100) chk("accept_timeout", waited, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec_a    = VW'($urandom);
        vec_b    = VW'($urandom);
    endtask

    // Feed table pairs first..first+count-1 back to back and check the whole stream.
    task automatic run_burst(input int first, input int count);
        int lat;
        @(posedge clk);
        #1;
        fork
            for (int p = first; p < first + count; p++) drive_pair(t_a[p], t_b[p], t_wait[p]);
            begin
                lat = 0;
                @(negedge clk);
                while (!frame_start && lat < 20) begin
                    lat++;
                    @(negedge clk);
                end
                chk("first_latency", lat, 2);
                for (int k = 0; k <= 6 * count; k++) begin
                    int fr;
                    int pos;
                    logic [DW-1:0] e;
                    if (k > 0) @(negedge clk);
                    fr  = k / 6;
                    pos = k % 6;
                    if (k < 6 * count) begin
                        e = (pos < 3) ? t_a[first+fr][pos*8 +: 8] : t_b[first+fr][(pos-3)*8 +: 8];
                        chk("dout_valid", dout_valid, 1);
                        chk("dout", dout, e);
                        chk("frame_start", frame_start, (pos == 0) ? 1 : 0);
                        chk("frame_last", frame_last, (pos == 5) ? 1 : 0);
                    end else begin
                        chk("idle_valid", dout_valid, 0);
                        chk("idle_dout", dout, 0);
                    end
                    chk("exp_valid", exp_valid, (k > 0 && pos == 0) ? 1 : 0);
                    if (k > 0 && pos == 0) chk("exp_result", exp_result, t_exp[first+fr-1]);
                end
            end
        join
    endtask

    // Engine model: deserialises the stream and recomputes the dot product.
    initial begin
        eng_pos = 0; eng_in = 1'b0; eng_prev_last = 1'b0; eng_dot = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                eng_pos = 0; eng_in = 1'b0; eng_prev_last = 1'b0;
            end else begin
                if (eng_prev_last || exp_valid) begin
                    chk("eng_exp_valid", exp_valid, eng_prev_last);
                    if (exp_valid && eng_prev_last) begin
                        chk("eng_result", exp_result, eng_dot);
                        eng_frames++;
                    end
                end
                eng_prev_last = 1'b0;
                if (eng_in) chk("eng_contig", dout_valid, 1);
                if (dout_valid) begin
                    if (frame_start) eng_pos = 0;
                    if (eng_pos < 2 * N) eng_el[eng_pos] = dout;
                    eng_pos++;
                    eng_in = 1'b1;
                    if (frame_last) begin
                        chk("eng_len", eng_pos, 2 * N);
                        eng_dot = 0;
                        for (int i = 0; i < N; i++) eng_dot += eng_el[i] * eng_el[i+N];
                        eng_prev_last = 1'b1;
                        eng_in = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        int base;
        reset = 1'b1; in_valid = 1'b0; vec_a = '0; vec_b = '0;
        t_a[0] = v3(1, 2, 3);       t_b[0] = v3(4, 5, 6);       t_exp[0] = 32;     t_wait[0] = 0;
        t_a[1] = v3(255, 255, 255); t_b[1] = v3(255, 255, 255); t_exp[1] = 195075; t_wait[1] = 0;
        t_a[2] = v3(1, 1, 1);       t_b[2] = v3(2, 2, 2);       t_exp[2] = 6;      t_wait[2] = 0;
        t_a[3] = v3(3, 0, 7);       t_b[3] = v3(1, 9, 2);       t_exp[3] = 17;     t_wait[3] = 0;
        t_a[4] = v3(10, 20, 30);    t_b[4] = v3(1, 2, 3);       t_exp[4] = 140;    t_wait[4] = 0;
        t_a[5] = v3(5, 5, 5);       t_b[5] = v3(5, 5, 5);       t_exp[5] = 75;     t_wait[5] = 0;
        t_a[6] = v3(0, 255, 1);     t_b[6] = v3(255, 255, 0);   t_exp[6] = 65025;  t_wait[6] = 5;

        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_last", frame_last, 0);
        chk("rst_exp_result", exp_result, 0);
        chk("rst_exp_valid", exp_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        run_burst(0, 1);
        @(negedge clk);
        chk("hold_exp_valid", exp_valid, 0);
        chk("hold_exp_result", exp_result, 32);
        run_burst(1, 1);
        chk("full_scale", exp_result, 18'h2FA03);
        run_burst(2, 2);
        run_burst(4, 3);

        // Reset in SEND_B idx 1: frame dropped, no result pulse.
        @(posedge clk);
        #1;
        drive_pair(v3(7, 8, 9), v3(1, 1, 1), 0);
        lat = 0;
        @(negedge clk);
        while (!frame_start && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("mid_rst_start", frame_start, 1);
        repeat (4) @(negedge clk);
        chk("mid_rst_in_b", dout, 8'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_last", frame_last, 0);
        chk("mid_rst_result", exp_result, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        chk("mid_rst_exp_valid", exp_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", in_ready, 1);
            chk("post_rst_exp_valid", exp_valid, 0);
            chk("post_rst_valid", dout_valid, 0);
        end
        run_burst(0, 1);

        // Random frames checked by the engine model.
        base = eng_frames;
        @(posedge clk);
        #1;
        for (int f = 0; f < 1000; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
            end
            drive_pair(VW'($urandom), VW'($urandom), -1);
        end
        repeat (20) @(negedge clk);
        chk("eng_frames", eng_frames - base, 1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
